// File: rtl/buf_arb_pkg.sv
// Shared types and constants for the endpoint data buffer arbiter.
// The build option BUF_TIMEOUT_EN is consumed by data_buffer_arbiter.
package buf_arb_pkg;

    localparam int BUF_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOST_FILL  = 3'd1,
        ST_TX_SEND    = 3'd2,
        ST_RX_FILL    = 3'd3,
        ST_HOST_DRAIN = 3'd4
    } arb_state_e;

endpackage

// File: rtl/data_buffer_arbiter_if.sv
// Request/strobe bundle between the requesters, the data buffer and the arbiter.
// master = environment side (requesters + buffer), slave = arbiter side.
interface data_buffer_arbiter_if;

    logic [6:0] buffer_occupancy;
    logic       host_wr;
    logic       host_rd;
    logic       host_tx_go;
    logic       rx_start;
    logic       rx_store;
    logic       rx_done;
    logic       rx_error;
    logic       tx_get;
    logic       tx_done;

    logic       store_tx_data;
    logic       store_rx_packet_data;
    logic       get_rx_data;
    logic       get_tx_packet_data;
    logic       flush;
    logic       clear;
    logic       tx_send;
    logic       rx_nak;
    logic       rx_data_ready;
    logic       overflow_err;
    logic       underrun_err;
    logic [2:0] arb_state;

    modport master (
        output buffer_occupancy, host_wr, host_rd, host_tx_go, rx_start,
               rx_store, rx_done, rx_error, tx_get, tx_done,
        input  store_tx_data, store_rx_packet_data, get_rx_data,
               get_tx_packet_data, flush, clear, tx_send, rx_nak,
               rx_data_ready, overflow_err, underrun_err, arb_state
    );

    modport slave (
        input  buffer_occupancy, host_wr, host_rd, host_tx_go, rx_start,
               rx_store, rx_done, rx_error, tx_get, tx_done,
        output store_tx_data, store_rx_packet_data, get_rx_data,
               get_tx_packet_data, flush, clear, tx_send, rx_nak,
               rx_data_ready, overflow_err, underrun_err, arb_state
    );

endinterface

// File: rtl/buf_arb_timer.sv
// RX inter-byte watchdog: counts enabled cycles since the last restart and
// flags expiry on the LIMIT-th consecutive enabled cycle without a restart.
module buf_arb_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == CW'(LIMIT - 1));
    assign expired    = enable && !restart && w_at_limit;

    // Saturating cycle counter, cleared by reset or restart
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (enable && !w_at_limit) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/data_buffer_arbiter.sv
// Ownership arbiter for the 64-byte endpoint buffer (host / USB RX / USB TX).
// Optional RX watchdog enabled by defining BUF_TIMEOUT_EN.
module data_buffer_arbiter
    import buf_arb_pkg::*;
#(
    parameter int DEPTH          = BUF_DEPTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    data_buffer_arbiter_if.slave  bus
);

    if (DEPTH < 1 || DEPTH > 127 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("data_buffer_arbiter: DEPTH must be 1..127 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_e r_state;
    arb_state_e w_next;
    logic       r_rx_data_ready;

    logic w_has_room;
    logic w_has_data;
    logic w_last_byte;
    logic w_timeout;

    logic w_store_tx, w_store_rx, w_get_rx, w_get_tx;
    logic w_flush, w_clear, w_tx_send, w_rx_nak, w_overflow, w_underrun;

    assign w_has_room  = (bus.buffer_occupancy < 7'(DEPTH));
    assign w_has_data  = (bus.buffer_occupancy != 7'd0);
    assign w_last_byte = (bus.buffer_occupancy == 7'd1);

`ifdef BUF_TIMEOUT_EN
    logic w_tmr_restart;
    logic w_tmr_enable;

    assign w_tmr_restart = (r_state != ST_RX_FILL) || bus.rx_store;
    assign w_tmr_enable  = (r_state == ST_RX_FILL);

    buf_arb_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (w_tmr_restart),
        .enable  (w_tmr_enable),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and gated strobes; everything stays low while rst is held
    always_comb begin
        w_next     = r_state;
        w_store_tx = 1'b0;
        w_store_rx = 1'b0;
        w_get_rx   = 1'b0;
        w_get_tx   = 1'b0;
        w_flush    = 1'b0;
        w_clear    = 1'b0;
        w_tx_send  = 1'b0;
        w_rx_nak   = 1'b0;
        w_overflow = 1'b0;
        w_underrun = 1'b0;
        if (rst) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_start) begin
                        w_next     = ST_RX_FILL;
                        w_flush    = 1'b1;
                        w_overflow = bus.host_wr;
                    end else if (bus.host_wr) begin
                        w_next     = ST_HOST_FILL;
                        w_store_tx = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_HOST_FILL: begin
                    w_store_tx = bus.host_wr && w_has_room;
                    w_overflow = bus.host_wr && !w_has_room;
                    w_rx_nak   = bus.rx_start;
                    if (bus.host_tx_go) begin
                        w_next    = ST_TX_SEND;
                        w_tx_send = 1'b1;
                    end else begin
                        w_next = ST_HOST_FILL;
                    end
                end
                ST_TX_SEND: begin
                    w_get_tx   = bus.tx_get && w_has_data;
                    w_underrun = bus.tx_get && !w_has_data;
                    w_rx_nak   = bus.rx_start;
                    if (bus.tx_done) begin
                        w_next  = ST_IDLE;
                        w_flush = 1'b1;
                    end else begin
                        w_next = ST_TX_SEND;
                    end
                end
                ST_RX_FILL: begin
                    w_store_rx = bus.rx_store && w_has_room;
                    w_overflow = bus.rx_store && !w_has_room;
                    // A watchdog expiry is handled exactly like a bad packet
                    if (bus.rx_error || w_timeout) begin
                        w_next  = ST_IDLE;
                        w_clear = 1'b1;
                    end else if (bus.rx_done) begin
                        w_next = ST_HOST_DRAIN;
                    end else begin
                        w_next = ST_RX_FILL;
                    end
                end
                ST_HOST_DRAIN: begin
                    w_get_rx   = bus.host_rd && w_has_data;
                    w_underrun = bus.host_rd && !w_has_data;
                    w_overflow = bus.host_wr;
                    w_rx_nak   = bus.rx_start;
                    if (bus.host_rd && w_last_byte) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_HOST_DRAIN;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register and the registered drain-ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rx_data_ready <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_rx_data_ready <= (w_next == ST_HOST_DRAIN);
        end
    end

    assign bus.store_tx_data        = w_store_tx;
    assign bus.store_rx_packet_data = w_store_rx;
    assign bus.get_rx_data          = w_get_rx;
    assign bus.get_tx_packet_data   = w_get_tx;
    assign bus.flush                = w_flush;
    assign bus.clear                = w_clear;
    assign bus.tx_send              = w_tx_send;
    assign bus.rx_nak               = w_rx_nak;
    assign bus.overflow_err         = w_overflow;
    assign bus.underrun_err         = w_underrun;
    assign bus.rx_data_ready        = r_rx_data_ready && !rst;
    assign bus.arb_state            = rst ? ST_IDLE : r_state;

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Self-checking bench for data_buffer_arbiter: directed scenarios plus random
// traffic against a rule-level reference model and a simple buffer model.
module tb_data_buffer_arbiter;
    import buf_arb_pkg::*;

`ifdef BUF_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic hwr, hrd, go, rxs, rxst, rxd, rxe, txg, txd;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_buffer_arbiter_if bus ();

    data_buffer_arbiter #(
        .DEPTH          (64),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    arb_state_e m_st  = ST_IDLE;
    int         m_idle = 0;
    int         occ    = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector: {stx,srx,grx,gtx,flush,clear,tx_send,nak,rdy,ovf,unr,state[2:0]}
    function automatic logic [13:0] model(input logic r, input req_t q, input int o,
                                          output arb_state_e nx);
        logic stx, srx, grx, gtx, fl, cl, txs, nak, ovf, unr, tmo;
        {stx, srx, grx, gtx, fl, cl, txs, nak, ovf, unr} = '0;
        nx = m_st;
        if (r) begin
            nx = ST_IDLE;
            return 14'd0;
        end
        case (m_st)
            ST_IDLE: begin
                if (q.rxs) begin nx = ST_RX_FILL; fl = 1'b1; ovf = q.hwr; end
                else if (q.hwr) begin nx = ST_HOST_FILL; stx = 1'b1; end
            end
            ST_HOST_FILL: begin
                if (q.hwr) begin if (o < 64) stx = 1'b1; else ovf = 1'b1; end
                if (q.go) begin nx = ST_TX_SEND; txs = 1'b1; end
                nak = q.rxs;
            end
            ST_TX_SEND: begin
                if (q.txg) begin if (o > 0) gtx = 1'b1; else unr = 1'b1; end
                if (q.txd) begin nx = ST_IDLE; fl = 1'b1; end
                nak = q.rxs;
            end
            ST_RX_FILL: begin
                if (q.rxst) begin if (o < 64) srx = 1'b1; else ovf = 1'b1; end
                tmo = TO_EN && !q.rxst && (m_idle == TO - 1);
                if (q.rxe || tmo) begin nx = ST_IDLE; cl = 1'b1; end
                else if (q.rxd) nx = ST_HOST_DRAIN;
            end
            ST_HOST_DRAIN: begin
                if (q.hrd) begin
                    if (o > 0) grx = 1'b1; else unr = 1'b1;
                    if (o == 1) nx = ST_IDLE;
                end
                ovf = q.hwr;
                nak = q.rxs;
            end
            default: nx = ST_IDLE;
        endcase
        return {stx, srx, grx, gtx, fl, cl, txs, nak, (m_st == ST_HOST_DRAIN), ovf, unr, 3'(m_st)};
    endfunction

    task automatic step(input logic r, input req_t q);
        arb_state_e  nx;
        logic [13:0] e;
        logic [13:0] g;
        rst = r;
        bus.host_wr = q.hwr;   bus.host_rd = q.hrd;   bus.host_tx_go = q.go;
        bus.rx_start = q.rxs;  bus.rx_store = q.rxst; bus.rx_done = q.rxd;
        bus.rx_error = q.rxe;  bus.tx_get = q.txg;    bus.tx_done = q.txd;
        bus.buffer_occupancy = 7'(occ);
        @(negedge clk);
        e = model(r, q, occ, nx);
        g = {bus.store_tx_data, bus.store_rx_packet_data, bus.get_rx_data,
             bus.get_tx_packet_data, bus.flush, bus.clear, bus.tx_send, bus.rx_nak,
             bus.rx_data_ready, bus.overflow_err, bus.underrun_err, bus.arb_state};
        check_value("outputs", 32'(g), 32'(e));
        @(posedge clk);
        #1;
        if (!r && m_st == ST_RX_FILL && nx == ST_RX_FILL && !q.rxst) m_idle++;
        else m_idle = 0;
        m_st = nx;
        // Buffer model reacts to the strobes the DUT actually issued
        if (r || g[9] || g[8]) occ = 0;
        else begin
            if ((g[13] || g[12]) && occ < 64) occ++;
            if ((g[11] || g[10]) && occ > 0) occ--;
        end
    endtask

    task automatic step_n(input int n, input req_t q);
        for (int i = 0; i < n; i++) step(1'b0, q);
    endtask

    initial begin
        req_t q;
        q = '0;
        step(1'b1, q);
        step(1'b1, q);
        check_value("reset_state", 32'(bus.arb_state), 32'(ST_IDLE));

        q = '0; q.hwr = 1'b1; step_n(20, q);
        check_value("fill_occ", 32'(occ), 32'd20);
        q = '0; q.go = 1'b1;  step(1'b0, q);
        q = '0; q.txg = 1'b1; step_n(20, q);
        check_value("tx_drained", 32'(occ), 32'd0);
        q = '0; q.txd = 1'b1; step(1'b0, q);
        check_value("tx_done_idle", 32'(bus.arb_state), 32'(ST_IDLE));

        q = '0; q.rxs = 1'b1;  step(1'b0, q);
        q = '0; q.rxst = 1'b1; step_n(65, q);
        check_value("rx_full_occ", 32'(occ), 32'd64);
        q = '0; q.rxd = 1'b1;  step(1'b0, q);
        check_value("rx_ready", 32'(bus.rx_data_ready), 32'd1);

        q = '0; q.hrd = 1'b1; step_n(64, q);
        check_value("drain_idle", 32'(bus.arb_state), 32'(ST_IDLE));
        step(1'b0, q);
        check_value("drain_occ", 32'(occ), 32'd0);

        q = '0; q.rxs = 1'b1; q.hwr = 1'b1; step(1'b0, q);
        check_value("rx_wins", 32'(bus.arb_state), 32'(ST_RX_FILL));
        q = '0; q.rxe = 1'b1; step(1'b0, q);

        q = '0; q.hwr = 1'b1; step_n(5, q);
        q = '0; q.rxs = 1'b1; step(1'b0, q);
        check_value("nak_occ", 32'(occ), 32'd5);
        check_value("nak_state", 32'(bus.arb_state), 32'(ST_HOST_FILL));
        q = '0; q.go = 1'b1;  step(1'b0, q);
        q = '0; q.txg = 1'b1; step_n(2, q);
        q = '0; step(1'b1, q);
        step(1'b0, q);
        check_value("rst_mid_tx", 32'(bus.arb_state), 32'(ST_IDLE));

`ifdef BUF_TIMEOUT_EN
        q = '0; q.rxs = 1'b1;  step(1'b0, q);
        q = '0; q.rxst = 1'b1; step_n(3, q);
        q = '0; step_n(16, q);
        check_value("timeout_idle", 32'(bus.arb_state), 32'(ST_IDLE));
`endif

        for (int i = 0; i < 3000; i++) begin
            q.hwr  = ($urandom_range(0, 99) < 40);
            q.hrd  = ($urandom_range(0, 99) < 40);
            q.go   = ($urandom_range(0, 99) < 5);
            q.rxs  = ($urandom_range(0, 99) < 8);
            q.rxst = ($urandom_range(0, 99) < 50);
            q.rxd  = ($urandom_range(0, 99) < 4);
            q.rxe  = ($urandom_range(0, 99) < 2);
            q.txg  = ($urandom_range(0, 99) < 50);
            q.txd  = ($urandom_range(0, 99) < 4);
            step(($urandom_range(0, 999) < 3), q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
